// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: per-slot GAP/DRIVE sequencing,
// frame-aligned digit snapshot, blink masking. Optional SCAN_LZ_BLANK_EN blanks a leading zero in digit 3.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [3:0]  seg_in,
    output logic        seg_en,
    output logic        frame_start
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [0:0] GAP   = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [15:0]   snapshot;
    logic          slot_blank;

    // Slot state is implied by the prescaler; kept as a named signal for observation.
    logic [0:0] state;
    assign state = (pre == '0) ? GAP : DRIVE;

    logic slot_end;
    logic frame_end;
    assign slot_end  = (pre == PRE_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    logic [3:0] nibble;
    always_comb begin
        nibble = 4'h0;
        case (idx)
            2'd0: nibble = snapshot[3:0];
            2'd1: nibble = snapshot[7:4];
            2'd2: nibble = snapshot[11:8];
            2'd3: nibble = snapshot[15:12];
            default: nibble = 4'h0;
        endcase
    end

    logic lz_blank;
`ifdef SCAN_LZ_BLANK_EN
    assign lz_blank = (idx == 2'd3) && (snapshot[15:12] == 4'h0);
`else
    assign lz_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            idx         <= 2'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            snapshot    <= 16'h0000;
            slot_blank  <= 1'b0;
            an          <= 4'b1111;
            seg_in      <= 4'h0;
            seg_en      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pre <= slot_end ? '0 : pre + 1'b1;
            if (slot_end)
                idx <= idx + 2'd1;

            if (frame_end) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // Blink decision and digit snapshot are both latched in the dead-time cycle.
            if (state == GAP) begin
                slot_blank <= blink_phase & blink_mask[idx];
                if (idx == 2'd0)
                    snapshot <= digits;
            end

            frame_start <= (state == GAP) && (idx == 2'd0);

            if ((state == DRIVE) && !slot_blank && !lz_blank) begin
                an     <= ~(4'b0001 << idx);
                seg_in <= nibble;
                seg_en <= 1'b1;
            end else begin
                an     <= 4'b1111;
                seg_in <= 4'h0;
                seg_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (REFRESH_DIV=4, BLINK_DIV=2): a cycle-position model
// pushes expected outputs per clock; they are popped and checked after the edge.
module tb_display_scan_ctrl;
    localparam int RD = 4;
    localparam int BD = 2;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [3:0]  seg_in;
    logic        seg_en;
    logic        frame_start;

    display_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg_in      (seg_in),
        .seg_en      (seg_en),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic       en;
        logic [3:0] seg;
        logic       fs;
        logic       chk_seg;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: cycles since reset release, frame snapshot, current slot blank flag.
    int          tcount = 0;
    logic [15:0] m_snap = 16'h0000;
    logic        m_blank = 1'b0;

    task automatic model_push();
        exp_t e;
        int pos, slot, di, frame, phase;
        logic lz;
        e = '0;
        if (rst) begin
            e.an = 4'b1111; e.en = 1'b0; e.seg = 4'h0; e.fs = 1'b0; e.chk_seg = 1'b1;
            tcount = 0;
            m_snap = 16'h0000;
        end else begin
            pos   = tcount % RD;
            slot  = tcount / RD;
            di    = slot % 4;
            frame = slot / 4;
            phase = (frame / BD) % 2;
            if (pos == 0) begin
                m_blank = (phase == 1) && blink_mask[di];
                if (di == 0) m_snap = digits;
                e.an = 4'b1111; e.en = 1'b0; e.fs = (di == 0); e.chk_seg = 1'b0;
            end else begin
`ifdef SCAN_LZ_BLANK_EN
                lz = (di == 3) && (m_snap[15:12] == 4'h0);
`else
                lz = 1'b0;
`endif
                e.fs = 1'b0;
                if (m_blank || lz) begin
                    e.an = 4'b1111; e.en = 1'b0; e.chk_seg = 1'b0;
                end else begin
                    e.an = 4'b1111 ^ (4'b0001 << di);
                    e.en = 1'b1;
                    e.seg = m_snap[di*4 +: 4];
                    e.chk_seg = 1'b1;
                end
            end
            tcount++;
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        total++;
        assert (an === e.an) else begin
            bad++; $error("FAIL an cyc=%0d got=%b exp=%b", cyc, an, e.an);
        end
        total++;
        assert (seg_en === e.en) else begin
            bad++; $error("FAIL seg_en cyc=%0d got=%b exp=%b", cyc, seg_en, e.en);
        end
        total++;
        assert (frame_start === e.fs) else begin
            bad++; $error("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, e.fs);
        end
        if (e.chk_seg) begin
            total++;
            assert (seg_in === e.seg) else begin
                bad++; $error("FAIL seg_in cyc=%0d got=%h exp=%h", cyc, seg_in, e.seg);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst        = 1'b1;
        digits     = 16'h1234;
        blink_mask = 4'b0000;
        run(2);
        rst = 1'b0;

        // Two plain frames of 1234.
        run(32);

        // Digits change during the digit 1 slot; visible only next frame.
        run(6);
        digits = 16'h5678;
        run(26);

        // Blink digits 0,1; mask change mid-slot is deferred to the next slot.
        blink_mask = 4'b0011;
        run(6);
        blink_mask = 4'b1100;
        run(5);
        blink_mask = 4'b0011;
        run(16 * 5 - 11);
        blink_mask = 4'b0000;

        // Leading zero, then out-of-range BCD codes.
        digits = 16'h0959;
        run(32);
        digits = 16'hFA00;
        run(32);

        // Random digits and masks, one change per frame.
        for (int f = 0; f < 6; f++) begin
            digits     = 16'($urandom_range(0, 65535));
            blink_mask = 4'($urandom_range(0, 15));
            run(16);
        end
        blink_mask = 4'b0000;
        digits     = 16'h1234;

        // Reset pulse during DRIVE of digit 2.
        for (int k = 0; k < 16 && (tcount % 16) != 10; k++) step();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter BLINK_DIV, default 125, frames per blink half-period; legal range 1..1023.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port digits, input, 16, four BCD nibbles: [15:12] digit 3 (hours tens) down to [3:0] digit 0 (minutes units).
REQ-006 SHALL have port blink_mask, input, 4, bit i set means digit i flashes.
REQ-007 SHALL have port an, output, 4, active-low digit enables, one-hot-low when a digit is driven.
REQ-008 SHALL have port seg_in, output, 4, BCD code to the shared 7-segment decoder.
REQ-009 SHALL have port seg_en, output, 1, decoder enable; 0 forces all segments off.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse at start of each slot for digit 0.

Function
REQ-011 SHALL run a prescaler counting 0..REFRESH_DIV-1; terminal count ends the current slot.
REQ-012 SHALL scan digit index 0->1->2->3->0, advancing one index per slot; wrap from 3 to 0 starts a new frame.
REQ-013 SHALL use two-state FSM per slot: GAP (prescaler = 0, exactly 1 cycle), then DRIVE (prescaler 1..REFRESH_DIV-1).
REQ-014 In GAP, SHALL output an=4'b1111, seg_en=0 (anti-ghosting dead time).
REQ-015 In DRIVE for index i, SHALL output an with only bit i low, seg_in = snapshot nibble i, seg_en=1 unless blanked.
REQ-016 SHALL capture digits into a 16-bit snapshot register in the GAP cycle of digit 0's slot; mid-frame changes on digits SHALL NOT appear until next frame.
REQ-017 SHALL register all outputs; outputs reflect state one cycle after the state change, with no combinational input-to-output path.
REQ-018 SHALL keep a frame counter 0..BLINK_DIV-1; on wrap, blink_phase toggles.
REQ-019 When blink_phase=1 and blink_mask[i]=1 (sampled at GAP of slot i), digit i SHALL be blanked: an=4'b1111, seg_en=0 for that whole slot.
REQ-020 Nibble values 10..15 SHALL pass unmodified to seg_in with seg_en=1; blanking is the decoder's responsibility.
REQ-021 frame_start SHALL assert for exactly the GAP cycle of digit 0's slot.
REQ-022 blink_mask change mid-slot SHALL take effect at the next slot only.

Reset
REQ-023 On rst=1 at a clock edge: prescaler=0, index=0, frame counter=0, blink_phase=0, snapshot=16'h0000.
REQ-024 Reset output values: an=4'b1111, seg_en=0, seg_in=4'h0, frame_start=0.
REQ-025 rst asserted mid-slot SHALL abort the slot; first cycle after rst deasserts SHALL be GAP of digit 0 with frame_start=1.

Configuration
REQ-026 Macro SCAN_LZ_BLANK_EN SHALL enable leading-zero blanking.
REQ-027 With SCAN_LZ_BLANK_EN defined: if snapshot digit 3 = 0, digit 3 slot SHALL output an=4'b1111, seg_en=0; other digits unaffected.
REQ-028 Without SCAN_LZ_BLANK_EN: digit 3 = 0 SHALL be driven as a normal zero.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-029 Reset release, digits=16'h1234, mask=0 -> per 4-cycle slot: GAP then 3 cycles an=1110/seg_in=4, then 1101/3, 1011/2, 0111/1; frame_start every 16 cycles.
REQ-030 Change digits to 16'h5678 during digit 1 slot -> remaining slots show 3,2,1; next frame shows 8,7,6,5.
REQ-031 mask=4'b0011 -> frames 0-1 show all digits; frames 2-3 digits 0,1 slots an=1111, seg_en=0; pattern repeats every 4 frames.
REQ-032 digits=16'h0959 -> with SCAN_LZ_BLANK_EN digit 3 slot an=1111, seg_en=0; without it an=0111, seg_in=0, seg_en=1.
REQ-033 rst pulsed 1 cycle during DRIVE of digit 2 -> outputs return to reset values next cycle, then GAP of digit 0 with frame_start=1.
REQ-034 digits=16'hFA00 -> seg_in=F and A driven with seg_en=1 in slots 3 and 2.
